// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: icache read handshake, downstream stall/redirect, IF/ID outputs.
// Latency: n/a (signal bundle only).
// Backpressure: stall from decode, ihit from icache; master = fetch stage, slave = its environment.
interface fetch_stage_if;
  // icache side
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;
  // control from decode / branch resolution
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  // IF/ID side
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcplusfour_out;
  logic        valid_out;
  logic        halt_out;

  modport master (
    input  ihit, iload, stall, redirect_valid, redirect_pc,
    output imemREN, imemaddr, instr_out, pc_out, pcplusfour_out, valid_out, halt_out
  );

  modport slave (
    output ihit, iload, stall, redirect_valid, redirect_pc,
    input  imemREN, imemaddr, instr_out, pc_out, pcplusfour_out, valid_out, halt_out
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch: owns PC, drives icache reads, buffers a word while decode stalls, applies redirects.
// Latency: zero added; iload is forwarded to instr_out in the ihit cycle, 1 instr/cycle on back-to-back hits.
// Backpressure: stall parks the fetched word in buf_instr (HOLD, no icache reads) until released or redirected.
// Ports: CLK, nRST (async active-low), fif (master): ihit/iload/imemREN/imemaddr to icache,
//        stall/redirect_valid/redirect_pc from downstream, instr_out/pc_out/pcplusfour_out/valid_out/halt_out to IF/ID.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic          CLK,
  input  logic          nRST,
  fetch_stage_if.master fif
);

  typedef enum logic [1:0] {FETCH, HOLD, DRAIN, HALTED} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] buf_instr;
  logic [31:0] pend_pc;
  logic [31:0] pc_next_seq;

  assign pc_next_seq = pc + 32'd4;

  // Outputs are combinational from state/registers and the current inputs.
  always_comb begin
    fif.imemREN        = 1'b0;
    fif.imemaddr       = pc;
    fif.valid_out      = 1'b0;
    fif.instr_out      = 32'h0;
    fif.halt_out       = 1'b0;
    fif.pc_out         = pc;
    fif.pcplusfour_out = pc_next_seq;
    case (state)
      FETCH: begin
        fif.imemREN = 1'b1;
        if (fif.ihit && !fif.redirect_valid && !fif.stall) begin
          fif.valid_out = 1'b1;
          fif.instr_out = fif.iload;
        end
      end
      HOLD: begin
        if (!fif.redirect_valid && !fif.stall) begin
          fif.valid_out = 1'b1;
          fif.instr_out = buf_instr;
        end
      end
      // The request in flight keeps its original address until the cache answers.
      DRAIN:   fif.imemREN  = 1'b1;
      HALTED:  fif.halt_out = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      buf_instr <= 32'h0;
      pend_pc   <= 32'h0;
    end else begin
      case (state)
        FETCH: begin
          if (fif.ihit) begin
            if (fif.redirect_valid) begin
              pc <= fif.redirect_pc;
            end else if (fif.stall) begin
              buf_instr <= fif.iload;
              state     <= HOLD;
            end else begin
              pc <= pc_next_seq;
              if (fif.iload[31:26] == HALT_OP) state <= HALTED;
            end
          end else if (fif.redirect_valid) begin
            // Cannot retarget a live request; remember the target and drain it.
            pend_pc <= fif.redirect_pc;
            state   <= DRAIN;
          end
        end
        HOLD: begin
          // A redirect squashes the buffered word even if stall releases this cycle.
          if (fif.redirect_valid) begin
            pc    <= fif.redirect_pc;
            state <= FETCH;
          end else if (!fif.stall) begin
            pc    <= pc_next_seq;
            state <= (buf_instr[31:26] == HALT_OP) ? HALTED : FETCH;
          end
        end
        DRAIN: begin
          if (fif.redirect_valid) pend_pc <= fif.redirect_pc;
          if (fif.ihit) begin
            pc    <= fif.redirect_valid ? fif.redirect_pc : pend_pc;
            state <= FETCH;
          end
        end
        HALTED: begin
          // A HALT fetched down a mispredicted path is undone by the redirect.
          if (fif.redirect_valid) begin
            pc    <= fif.redirect_pc;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic CLK;
  logic nRST;
  int   vecs;
  int   fails;

  fetch_stage_if ifc ();
  fetch_stage_if wfc ();

  fetch_stage #(.PC_INIT(32'h00000000), .HALT_OP(6'b111111)) dut (
    .CLK(CLK), .nRST(nRST), .fif(ifc)
  );

  fetch_stage #(.PC_INIT(32'hFFFFFFFC), .HALT_OP(6'b111111)) u_wrap (
    .CLK(CLK), .nRST(nRST), .fif(wfc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    ifc.ihit = 1'b0; ifc.iload = 32'h0; ifc.stall = 1'b0;
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = 32'h0;
    wfc.ihit = 1'b0; wfc.iload = 32'h0; wfc.stall = 1'b0;
    wfc.redirect_valid = 1'b0; wfc.redirect_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 nRST = 1'b0;
    #3;
    cyc();
    nRST = 1'b1;
    #1;
  endtask

  // n back-to-back hits returning nops.
  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) begin
      ifc.ihit = 1'b1; ifc.iload = 32'h0;
      cyc();
    end
    ifc.ihit = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    #3;
    vecs++; if (ifc.imemREN !== 1'b1) begin fails++; $display("FAIL reset_ren got %b exp 1", ifc.imemREN); end
    vecs++; if (ifc.imemaddr !== 32'h0) begin fails++; $display("FAIL reset_addr got %h exp 00000000", ifc.imemaddr); end
    vecs++; if (ifc.valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", ifc.valid_out); end
    vecs++; if (ifc.instr_out !== 32'h0) begin fails++; $display("FAIL reset_instr got %h exp 00000000", ifc.instr_out); end
    vecs++; if (ifc.pc_out !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp 00000000", ifc.pc_out); end
    vecs++; if (ifc.pcplusfour_out !== 32'h4) begin fails++; $display("FAIL reset_pc4 got %h exp 00000004", ifc.pcplusfour_out); end
    vecs++; if (ifc.halt_out !== 1'b0) begin fails++; $display("FAIL reset_halt got %b exp 0", ifc.halt_out); end
    cyc();
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      exp_pc = 32'(i) * 32'd4;
      ifc.ihit = 1'b1; ifc.iload = 32'h20010000 + 32'(i);
      #1;
      vecs++; if (ifc.imemaddr !== exp_pc) begin fails++; $display("FAIL b2b_addr%0d got %h exp %h", i, ifc.imemaddr, exp_pc); end
      vecs++; if (ifc.valid_out !== 1'b1) begin fails++; $display("FAIL b2b_valid%0d got %b exp 1", i, ifc.valid_out); end
      vecs++; if (ifc.instr_out !== 32'h20010000 + 32'(i)) begin fails++; $display("FAIL b2b_instr%0d got %h exp %h", i, ifc.instr_out, 32'h20010000 + 32'(i)); end
      vecs++; if (ifc.pc_out !== exp_pc) begin fails++; $display("FAIL b2b_pc%0d got %h exp %h", i, ifc.pc_out, exp_pc); end
      vecs++; if (ifc.pcplusfour_out !== exp_pc + 32'd4) begin fails++; $display("FAIL b2b_pc4_%0d got %h exp %h", i, ifc.pcplusfour_out, exp_pc + 32'd4); end
      cyc();
    end
    ifc.ihit = 1'b0;
  endtask

  task automatic test_miss();
    do_reset();
    run_hits(2);
    for (int i = 0; i < 3; i++) begin
      ifc.ihit = 1'b0;
      #1;
      vecs++; if (ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h8) begin fails++; $display("FAIL miss_req%0d got ren=%b addr=%h exp ren=1 addr=00000008", i, ifc.imemREN, ifc.imemaddr); end
      vecs++; if (ifc.valid_out !== 1'b0) begin fails++; $display("FAIL miss_valid%0d got %b exp 0", i, ifc.valid_out); end
      cyc();
    end
    ifc.ihit = 1'b1; ifc.iload = 32'h01234020;
    #1;
    vecs++; if (ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h8) begin fails++; $display("FAIL miss_hit_req got ren=%b addr=%h exp ren=1 addr=00000008", ifc.imemREN, ifc.imemaddr); end
    vecs++; if (ifc.valid_out !== 1'b1 || ifc.pc_out !== 32'h8 || ifc.instr_out !== 32'h01234020) begin fails++; $display("FAIL miss_hit got v=%b pc=%h i=%h exp v=1 pc=00000008 i=01234020", ifc.valid_out, ifc.pc_out, ifc.instr_out); end
    cyc();
    ifc.ihit = 1'b0;
    #1;
    vecs++; if (ifc.imemaddr !== 32'hC) begin fails++; $display("FAIL miss_next got %h exp 0000000c", ifc.imemaddr); end
  endtask

  task automatic test_stall();
    do_reset();
    run_hits(4);
    ifc.ihit = 1'b1; ifc.iload = 32'h8C220004; ifc.stall = 1'b1;
    #1;
    vecs++; if (ifc.valid_out !== 1'b0 || ifc.pc_out !== 32'h10) begin fails++; $display("FAIL stall_hit got v=%b pc=%h exp v=0 pc=00000010", ifc.valid_out, ifc.pc_out); end
    cyc();
    ifc.ihit = 1'b0; ifc.iload = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      #1;
      vecs++; if (ifc.imemREN !== 1'b0 || ifc.valid_out !== 1'b0) begin fails++; $display("FAIL stall_hold%0d got ren=%b v=%b exp ren=0 v=0", i, ifc.imemREN, ifc.valid_out); end
      cyc();
    end
    ifc.stall = 1'b0;
    #1;
    vecs++; if (ifc.valid_out !== 1'b1 || ifc.instr_out !== 32'h8C220004 || ifc.pc_out !== 32'h10) begin fails++; $display("FAIL stall_release got v=%b i=%h pc=%h exp v=1 i=8c220004 pc=00000010", ifc.valid_out, ifc.instr_out, ifc.pc_out); end
    cyc();
    #1;
    vecs++; if (ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h14) begin fails++; $display("FAIL stall_next got ren=%b addr=%h exp ren=1 addr=00000014", ifc.imemREN, ifc.imemaddr); end
  endtask

  task automatic test_drain();
    do_reset();
    run_hits(2);
    ifc.ihit = 1'b0; ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h40;
    #1;
    vecs++; if (ifc.imemaddr !== 32'h8 || ifc.valid_out !== 1'b0) begin fails++; $display("FAIL drain_enter got addr=%h v=%b exp addr=00000008 v=0", ifc.imemaddr, ifc.valid_out); end
    cyc();
    ifc.redirect_valid = 1'b0; ifc.redirect_pc = 32'h0;
    #1;
    vecs++; if (ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h8) begin fails++; $display("FAIL drain_wait got ren=%b addr=%h exp ren=1 addr=00000008", ifc.imemREN, ifc.imemaddr); end
    cyc();
    ifc.ihit = 1'b1; ifc.iload = 32'h11111111;
    #1;
    vecs++; if (ifc.valid_out !== 1'b0 || ifc.imemaddr !== 32'h8) begin fails++; $display("FAIL drain_hit got v=%b addr=%h exp v=0 addr=00000008", ifc.valid_out, ifc.imemaddr); end
    cyc();
    ifc.ihit = 1'b0;
    #1;
    vecs++; if (ifc.imemaddr !== 32'h40 || ifc.pc_out !== 32'h40) begin fails++; $display("FAIL drain_target got addr=%h pc=%h exp 00000040", ifc.imemaddr, ifc.pc_out); end
  endtask

  task automatic test_halt();
    do_reset();
    run_hits(8);
    ifc.ihit = 1'b1; ifc.iload = 32'hFC000000;
    #1;
    vecs++; if (ifc.valid_out !== 1'b1 || ifc.instr_out !== 32'hFC000000 || ifc.pc_out !== 32'h20) begin fails++; $display("FAIL halt_fetch got v=%b i=%h pc=%h exp v=1 i=fc000000 pc=00000020", ifc.valid_out, ifc.instr_out, ifc.pc_out); end
    cyc();
    ifc.iload = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (ifc.halt_out !== 1'b1 || ifc.imemREN !== 1'b0 || ifc.valid_out !== 1'b0) begin fails++; $display("FAIL halt_idle%0d got h=%b ren=%b v=%b exp h=1 ren=0 v=0", i, ifc.halt_out, ifc.imemREN, ifc.valid_out); end
      cyc();
    end
    ifc.ihit = 1'b0; ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h100;
    cyc();
    ifc.redirect_valid = 1'b0;
    #1;
    vecs++; if (ifc.imemaddr !== 32'h100 || ifc.halt_out !== 1'b0 || ifc.imemREN !== 1'b1) begin fails++; $display("FAIL halt_resume got addr=%h h=%b ren=%b exp addr=00000100 h=0 ren=1", ifc.imemaddr, ifc.halt_out, ifc.imemREN); end
  endtask

  task automatic test_redirect_stall_wrap();
    do_reset();
    ifc.ihit = 1'b1; ifc.iload = 32'h22222222; ifc.stall = 1'b1;
    ifc.redirect_valid = 1'b1; ifc.redirect_pc = 32'h80;
    #1;
    vecs++; if (ifc.valid_out !== 1'b0) begin fails++; $display("FAIL rs_valid got %b exp 0", ifc.valid_out); end
    cyc();
    idle_inputs();
    #1;
    vecs++; if (ifc.imemREN !== 1'b1 || ifc.imemaddr !== 32'h80) begin fails++; $display("FAIL rs_next got ren=%b addr=%h exp ren=1 addr=00000080", ifc.imemREN, ifc.imemaddr); end
    // PC wrap on the instance reset to the top of the address space
    do_reset();
    vecs++; if (wfc.imemaddr !== 32'hFFFFFFFC || wfc.pcplusfour_out !== 32'h0) begin fails++; $display("FAIL wrap_reset got addr=%h pc4=%h exp fffffffc/00000000", wfc.imemaddr, wfc.pcplusfour_out); end
    wfc.ihit = 1'b1; wfc.iload = 32'h0;
    #1;
    vecs++; if (wfc.valid_out !== 1'b1) begin fails++; $display("FAIL wrap_valid got %b exp 1", wfc.valid_out); end
    cyc();
    wfc.ihit = 1'b0;
    #1;
    vecs++; if (wfc.imemaddr !== 32'h0) begin fails++; $display("FAIL wrap_next got %h exp 00000000", wfc.imemaddr); end
  endtask

  initial begin
    vecs  = 0;
    fails = 0;
    nRST  = 1'b1;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_miss();
    test_stall();
    test_drain();
    test_halt();
    test_redirect_stall_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
